// File: rtl/split_two.sv
// split_two: packet-granular 1-to-2 wormhole demultiplexer.
// A HEAD flit picks port A or B from payload bit SEL_BIT. The route stays
// locked until that packet's TAIL fires. A 2-entry FIFO sits in front so
// ready_o is a flop and never depends combinationally on the port readies.

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef HEAD
`define HEAD 2'b10
`endif
`ifndef BODY
`define BODY 2'b00
`endif
`ifndef TAIL
`define TAIL 2'b01
`endif

module split_two #(
  parameter int SEL_BIT   = 0,   // must be < DATA_WIDTH-2 (payload bit)
  parameter int CNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [`DATA_WIDTH-1:0] data_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  output logic [`DATA_WIDTH-1:0] A_data_o,
  output logic                   A_valid_o,
  input  logic                   A_ready_i,
  output logic [`DATA_WIDTH-1:0] B_data_o,
  output logic                   B_valid_o,
  input  logic                   B_ready_i,
  output logic [CNT_WIDTH-1:0]   A_pkt_cnt_o,
  output logic [CNT_WIDTH-1:0]   B_pkt_cnt_o,
  output logic                   proto_err_o
);

  localparam int DW = `DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, ROUTE_A, ROUTE_B} state_e;

  // FIFO storage and bookkeeping
  logic [1:0][DW-1:0]   mem_q, mem_d;
  logic                 wr_ptr_q, wr_ptr_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic [1:0]           cnt_q, cnt_d;
  logic                 ready_q, ready_d;

  // routing state and statistics
  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] a_cnt_q, a_cnt_d;
  logic [CNT_WIDTH-1:0] b_cnt_q, b_cnt_d;

  logic [DW-1:0]        head;
  logic [1:0]           head_type;
  logic                 empty;
  logic                 push, pop, fire, drop;
  logic                 a_vld, b_vld;

  assign head      = mem_q[rd_ptr_q];
  assign head_type = head[DW-1:DW-2];
  assign empty     = (cnt_q == 2'd0);

  // Route FSM: choose the port in IDLE, stay locked until TAIL fires.
  always_comb begin
    state_d = state_q;
    a_vld   = 1'b0;
    b_vld   = 1'b0;
    fire    = 1'b0;
    drop    = 1'b0;
    a_cnt_d = a_cnt_q;
    b_cnt_d = b_cnt_q;
    if (!empty) begin
      unique case (state_q)
        IDLE: begin
          if (head_type == `HEAD) begin
            a_vld = ~head[SEL_BIT];
            b_vld =  head[SEL_BIT];
            fire  = head[SEL_BIT] ? B_ready_i : A_ready_i;
            if (fire) state_d = head[SEL_BIT] ? ROUTE_B : ROUTE_A;
          end else begin
            // a flit outside any packet has no route: discard it
            drop = 1'b1;
          end
        end
        ROUTE_A: begin
          a_vld = 1'b1;
          fire  = A_ready_i;
          if (fire && head_type == `TAIL) begin
            state_d = IDLE;
            a_cnt_d = a_cnt_q + 1'b1;
          end
        end
        ROUTE_B: begin
          b_vld = 1'b1;
          fire  = B_ready_i;
          if (fire && head_type == `TAIL) begin
            state_d = IDLE;
            b_cnt_d = b_cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FIFO next-state: push on accepted input, pop on fire or drop.
  always_comb begin
    push     = valid_i & ready_q;
    pop      = fire | drop;
    mem_d    = mem_q;
    if (push) mem_d[wr_ptr_q] = data_i;
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
    // registered full flag; computed from the next count so a pop frees
    // a slot for the very next cycle
    ready_d  = (cnt_d != 2'd2);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      mem_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
      ready_q  <= 1'b1;
      state_q  <= IDLE;
      a_cnt_q  <= '0;
      b_cnt_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      state_q  <= state_d;
      a_cnt_q  <= a_cnt_d;
      b_cnt_q  <= b_cnt_d;
    end
  end

  assign ready_o     = ready_q;
  assign A_data_o    = head;
  assign B_data_o    = head;
  assign A_valid_o   = a_vld;
  assign B_valid_o   = b_vld;
  assign A_pkt_cnt_o = a_cnt_q;
  assign B_pkt_cnt_o = b_cnt_q;
  assign proto_err_o = drop;

endmodule

// File: tb/tb_split_two.sv
// Directed bench for split_two. Inputs change on the falling edge, outputs
// are checked on the falling edge after the rising edge that moved them.

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef HEAD
`define HEAD 2'b10
`endif
`ifndef BODY
`define BODY 2'b00
`endif
`ifndef TAIL
`define TAIL 2'b01
`endif

module tb_split_two;
  localparam int DW = `DATA_WIDTH;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rstn;
  logic [DW-1:0] data_i;
  logic          valid_i;
  logic          ready_o;
  logic [DW-1:0] A_data_o, B_data_o;
  logic          A_valid_o, B_valid_o;
  logic          A_ready_i, B_ready_i;
  logic [CW-1:0] A_pkt_cnt_o, B_pkt_cnt_o;
  logic          proto_err_o;

  int n_chk  = 0;
  int n_pass = 0;

  split_two #(.SEL_BIT(0), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rstn(rstn),
    .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
    .A_data_o(A_data_o), .A_valid_o(A_valid_o), .A_ready_i(A_ready_i),
    .B_data_o(B_data_o), .B_valid_o(B_valid_o), .B_ready_i(B_ready_i),
    .A_pkt_cnt_o(A_pkt_cnt_o), .B_pkt_cnt_o(B_pkt_cnt_o),
    .proto_err_o(proto_err_o)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] flit(input logic [1:0] t, input logic [DW-3:0] p);
    return {t, p};
  endfunction

  // one full cycle: rising edge moves state, falling edge is the check point
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0; valid_i = 1'b0; data_i = '0;
    A_ready_i = 1'b1; B_ready_i = 1'b1;
    step(); step();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if (ready_o !== 1'b1) $display("FAIL rst_ready got %0b exp 1", ready_o); else n_pass++;
    n_chk++; if (A_valid_o !== 1'b0) $display("FAIL rst_a_valid got %0b exp 0", A_valid_o); else n_pass++;
    n_chk++; if (B_valid_o !== 1'b0) $display("FAIL rst_b_valid got %0b exp 0", B_valid_o); else n_pass++;
    n_chk++; if (A_pkt_cnt_o !== 16'd0) $display("FAIL rst_a_cnt got %0d exp 0", A_pkt_cnt_o); else n_pass++;
    n_chk++; if (B_pkt_cnt_o !== 16'd0) $display("FAIL rst_b_cnt got %0d exp 0", B_pkt_cnt_o); else n_pass++;
    n_chk++; if (proto_err_o !== 1'b0) $display("FAIL rst_err got %0b exp 0", proto_err_o); else n_pass++;
  endtask

  // HEAD/BODY/TAIL to A, each flit visible one cycle after its push
  task automatic test_single_a();
    logic [DW-1:0] f [3];
    do_reset();
    f[0] = flit(`HEAD, 30'h0000_0A10);
    f[1] = flit(`BODY, 30'h0000_0A21);
    f[2] = flit(`TAIL, 30'h0000_0A33);
    for (int i = 0; i < 3; i++) begin
      data_i = f[i]; valid_i = 1'b1;
      step();
      n_chk++; if (A_valid_o !== 1'b1 || A_data_o !== f[i]) $display("FAIL single_a_flit%0d got v=%0b d=%h exp v=1 d=%h", i, A_valid_o, A_data_o, f[i]); else n_pass++;
      n_chk++; if (B_valid_o !== 1'b0) $display("FAIL single_a_bvalid%0d got %0b exp 0", i, B_valid_o); else n_pass++;
    end
    valid_i = 1'b0;
    step();
    n_chk++; if (A_valid_o !== 1'b0) $display("FAIL single_a_drain got %0b exp 0", A_valid_o); else n_pass++;
    n_chk++; if (A_pkt_cnt_o !== 16'd1) $display("FAIL single_a_cnt got %0d exp 1", A_pkt_cnt_o); else n_pass++;
    n_chk++; if (B_pkt_cnt_o !== 16'd0) $display("FAIL single_a_bcnt got %0d exp 0", B_pkt_cnt_o); else n_pass++;
  endtask

  // 2-flit packet to B, then 4-flit packet to A, no gaps on the input
  task automatic test_back_to_back();
    logic [DW-1:0] f [6];
    logic          to_b [6];
    do_reset();
    f[0] = flit(`HEAD, 30'h0000_0B01); to_b[0] = 1'b1;
    f[1] = flit(`TAIL, 30'h0000_0B12); to_b[1] = 1'b1;
    f[2] = flit(`HEAD, 30'h0000_0A20); to_b[2] = 1'b0;
    f[3] = flit(`BODY, 30'h0000_0A31); to_b[3] = 1'b0;
    f[4] = flit(`BODY, 30'h0000_0A42); to_b[4] = 1'b0;
    f[5] = flit(`TAIL, 30'h0000_0A53); to_b[5] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      data_i = f[i]; valid_i = 1'b1;
      step();
      if (to_b[i]) begin
        n_chk++; if (B_valid_o !== 1'b1 || A_valid_o !== 1'b0 || B_data_o !== f[i]) $display("FAIL b2b_flit%0d got bv=%0b av=%0b d=%h exp bv=1 av=0 d=%h", i, B_valid_o, A_valid_o, B_data_o, f[i]); else n_pass++;
      end else begin
        n_chk++; if (A_valid_o !== 1'b1 || B_valid_o !== 1'b0 || A_data_o !== f[i]) $display("FAIL b2b_flit%0d got av=%0b bv=%0b d=%h exp av=1 bv=0 d=%h", i, A_valid_o, B_valid_o, A_data_o, f[i]); else n_pass++;
      end
    end
    valid_i = 1'b0;
    step();
    n_chk++; if (A_pkt_cnt_o !== 16'd1) $display("FAIL b2b_a_cnt got %0d exp 1", A_pkt_cnt_o); else n_pass++;
    n_chk++; if (B_pkt_cnt_o !== 16'd1) $display("FAIL b2b_b_cnt got %0d exp 1", B_pkt_cnt_o); else n_pass++;
  endtask

  // stall port A mid-packet; input fills, B_ready toggles harmlessly
  task automatic test_backpressure();
    logic [DW-1:0] h, b1, b2, b3, t;
    do_reset();
    h  = flit(`HEAD, 30'h0000_0C00);
    b1 = flit(`BODY, 30'h0000_0C12);
    b2 = flit(`BODY, 30'h0000_0C24);
    b3 = flit(`BODY, 30'h0000_0C36);
    t  = flit(`TAIL, 30'h0000_0C48);
    data_i = h; valid_i = 1'b1;
    step();
    data_i = b1;
    step();
    A_ready_i = 1'b0; data_i = b2;
    step();
    n_chk++; if (ready_o !== 1'b0) $display("FAIL bp_full_ready got %0b exp 0", ready_o); else n_pass++;
    data_i = b3;
    for (int i = 0; i < 3; i++) begin
      B_ready_i = ~B_ready_i;
      step();
      n_chk++; if (A_valid_o !== 1'b1 || A_data_o !== b1 || B_valid_o !== 1'b0) $display("FAIL bp_hold%0d got av=%0b d=%h bv=%0b exp av=1 d=%h bv=0", i, A_valid_o, A_data_o, B_valid_o, b1); else n_pass++;
      n_chk++; if (ready_o !== 1'b0) $display("FAIL bp_ready%0d got %0b exp 0", i, ready_o); else n_pass++;
    end
    A_ready_i = 1'b1; B_ready_i = 1'b1;
    step();
    n_chk++; if (A_data_o !== b2 || ready_o !== 1'b1) $display("FAIL bp_rel1 got d=%h r=%0b exp d=%h r=1", A_data_o, ready_o, b2); else n_pass++;
    step();
    n_chk++; if (A_data_o !== b3 || A_valid_o !== 1'b1) $display("FAIL bp_rel2 got d=%h v=%0b exp d=%h v=1", A_data_o, A_valid_o, b3); else n_pass++;
    data_i = t;
    step();
    n_chk++; if (A_data_o !== t || A_valid_o !== 1'b1) $display("FAIL bp_tail got d=%h v=%0b exp d=%h v=1", A_data_o, A_valid_o, t); else n_pass++;
    valid_i = 1'b0;
    step();
    n_chk++; if (A_valid_o !== 1'b0 || A_pkt_cnt_o !== 16'd1) $display("FAIL bp_done got v=%0b cnt=%0d exp v=0 cnt=1", A_valid_o, A_pkt_cnt_o); else n_pass++;
  endtask

  // BODY and TAIL outside a packet are dropped with an error pulse
  task automatic test_stray();
    logic [DW-1:0] h, t;
    do_reset();
    data_i = flit(`BODY, 30'h0000_0D01); valid_i = 1'b1;
    step();
    n_chk++; if (proto_err_o !== 1'b1 || A_valid_o !== 1'b0 || B_valid_o !== 1'b0) $display("FAIL stray_body got err=%0b av=%0b bv=%0b exp 1 0 0", proto_err_o, A_valid_o, B_valid_o); else n_pass++;
    data_i = flit(`TAIL, 30'h0000_0D02);
    step();
    n_chk++; if (proto_err_o !== 1'b1 || A_valid_o !== 1'b0 || B_valid_o !== 1'b0) $display("FAIL stray_tail got err=%0b av=%0b bv=%0b exp 1 0 0", proto_err_o, A_valid_o, B_valid_o); else n_pass++;
    h = flit(`HEAD, 30'h0000_0D13);
    data_i = h;
    step();
    n_chk++; if (proto_err_o !== 1'b0 || B_valid_o !== 1'b1 || B_data_o !== h) $display("FAIL stray_head got err=%0b bv=%0b d=%h exp 0 1 %h", proto_err_o, B_valid_o, B_data_o, h); else n_pass++;
    n_chk++; if (A_pkt_cnt_o !== 16'd0 || B_pkt_cnt_o !== 16'd0) $display("FAIL stray_cnt got a=%0d b=%0d exp 0 0", A_pkt_cnt_o, B_pkt_cnt_o); else n_pass++;
    t = flit(`TAIL, 30'h0000_0D24);
    data_i = t;
    step();
    n_chk++; if (B_valid_o !== 1'b1 || B_data_o !== t || proto_err_o !== 1'b0) $display("FAIL stray_ptail got bv=%0b d=%h err=%0b exp 1 %h 0", B_valid_o, B_data_o, proto_err_o, t); else n_pass++;
    valid_i = 1'b0;
    step();
    n_chk++; if (B_pkt_cnt_o !== 16'd1 || A_pkt_cnt_o !== 16'd0) $display("FAIL stray_end got b=%0d a=%0d exp 1 0", B_pkt_cnt_o, A_pkt_cnt_o); else n_pass++;
  endtask

  // reset while locked to B with two flits queued
  task automatic test_reset_mid();
    logic [DW-1:0] h;
    do_reset();
    data_i = flit(`HEAD, 30'h0000_0E01); valid_i = 1'b1;
    step();
    data_i = flit(`BODY, 30'h0000_0E12);
    step();
    B_ready_i = 1'b0; data_i = flit(`BODY, 30'h0000_0E24);
    step();
    n_chk++; if (B_valid_o !== 1'b1 || ready_o !== 1'b0) $display("FAIL mid_pre got bv=%0b r=%0b exp 1 0", B_valid_o, ready_o); else n_pass++;
    rstn = 1'b0; valid_i = 1'b0;
    step();
    n_chk++; if (ready_o !== 1'b1 || A_valid_o !== 1'b0 || B_valid_o !== 1'b0) $display("FAIL mid_rst got r=%0b av=%0b bv=%0b exp 1 0 0", ready_o, A_valid_o, B_valid_o); else n_pass++;
    rstn = 1'b1; B_ready_i = 1'b1;
    h = flit(`HEAD, 30'h0000_0E30);
    data_i = h; valid_i = 1'b1;
    step();
    n_chk++; if (A_valid_o !== 1'b1 || A_data_o !== h || B_valid_o !== 1'b0) $display("FAIL mid_newhead got av=%0b d=%h bv=%0b exp 1 %h 0", A_valid_o, A_data_o, B_valid_o, h); else n_pass++;
    data_i = flit(`TAIL, 30'h0000_0E41);
    step();
    valid_i = 1'b0;
    step();
    n_chk++; if (A_pkt_cnt_o !== 16'd1 || B_pkt_cnt_o !== 16'd0) $display("FAIL mid_cnt got a=%0d b=%0d exp 1 0", A_pkt_cnt_o, B_pkt_cnt_o); else n_pass++;
  endtask

  initial begin
    rstn = 1'b0; valid_i = 1'b0; data_i = '0;
    A_ready_i = 1'b1; B_ready_i = 1'b1;
    test_reset();
    test_single_a();
    test_back_to_back();
    test_backpressure();
    test_stray();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/split_two.md
Name: split_two

Overview:
- Packet-granular 1-to-2 demultiplexer. Steers one wormhole flit stream to one of two output ports.
- The route is chosen from a select bit in the HEAD flit. The port stays locked to that route until the TAIL flit is handed off.
- It is the fan-out counterpart of the router's two-input packet merger. It sits at router output stages and local-port ejection points.
- A 2-entry input buffer decouples the upstream ready from the downstream ready.

Parameters:
- SEL_BIT, 0: bit index in the HEAD flit payload that selects the route. 0 routes to port A, 1 routes to port B. Must be < `DATA_WIDTH-2.
- CNT_WIDTH, 16: width of the per-port completed-packet counters.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rstn  input  1  reset, synchronous, active-low.
- data_i  input  `DATA_WIDTH  input flit. Type field is [`DATA_WIDTH-1:`DATA_WIDTH-2] (`HEAD/`BODY/`TAIL from param.vh).
- valid_i  input  1  input flit valid.
- ready_o  output  1  input buffer can accept a flit.
- A_data_o  output  `DATA_WIDTH  port A flit.
- A_valid_o  output  1  port A valid.
- A_ready_i  input  1  port A ready.
- B_data_o  output  `DATA_WIDTH  port B flit.
- B_valid_o  output  1  port B valid.
- B_ready_i  input  1  port B ready.
- A_pkt_cnt_o  output  CNT_WIDTH  TAIL flits delivered on A.
- B_pkt_cnt_o  output  CNT_WIDTH  TAIL flits delivered on B.
- proto_err_o  output  1  one-cycle pulse when a flit is dropped (see below).

Behaviour:
- Reset (synchronous, rstn=0 at a rising edge):
  - buffer emptied; state=IDLE; counters=0; proto_err_o=0.
  - ready_o=1 after reset; A_valid_o=B_valid_o=0.
  - Reset mid-packet discards all buffered flits and the route lock.
- Input buffer: 2-entry circular FIFO.
  - ready_o = ~full, registered, with no combinational path from A_ready_i/B_ready_i.
  - Push when valid_i & ready_o. Pop when the head flit fires or is dropped.
  - Push and pop in the same cycle while full is impossible (ready_o=0). Push and pop in the same cycle while holding 1 entry leaves the count at 1.
  - Pointers wrap modulo 2.
- Latency: a flit pushed at edge N is visible on an output from cycle N+1. Sustained throughput is 1 flit/cycle when the selected port stays ready.
- Output data: A_data_o and B_data_o are both driven with the FIFO head flit. Only the selected port's valid is asserted. Unselected ports show valid=0.
- Route select (combinational): in IDLE, route = head_flit[SEL_BIT]. In a ROUTE state, route = the latched route.
- Fire: the selected valid & the selected ready.
- State machine, states IDLE, ROUTE_A, ROUTE_B:
  - IDLE, head type `HEAD: assert the valid of the port given by head_flit[SEL_BIT]. On fire, go to ROUTE_A or ROUTE_B.
  - IDLE, head type not `HEAD (`BODY/`TAIL/other): flit is popped and dropped. proto_err_o=1 that cycle; no output valid; stay IDLE.
  - ROUTE_x, any type: assert x_valid_o.
  - ROUTE_x, on fire of a `TAIL flit: go to IDLE and increment x_pkt_cnt_o.
  - ROUTE_x, on fire of any other type (including a second `HEAD): stay in ROUTE_x and forward the flit unchanged.
  - The next packet's HEAD may be issued the cycle after a TAIL fires, giving back-to-back packets with zero bubbles in the buffer.
- The ready of the non-selected port has no effect. A downstream stall on the locked port blocks the input; no reordering and no interleaving between packets.
- Counters wrap from 2^CNT_WIDTH-1 to 0.
- Valid stability: once an output valid is asserted, that valid and its data hold until fire (no retraction). An empty buffer gives valids=0.

Test Plan:
- Reset then idle: rstn=0 for 2 cycles -> ready_o=1, A_valid_o=B_valid_o=0, both counters 0, proto_err_o=0.
- 3-flit packet with HEAD[SEL_BIT]=0, both readies high -> flits on A at cycles 1, 2, 3 after push; B_valid_o never 1; A_pkt_cnt_o=1; state back to IDLE.
- Back-to-back packets, first 2 flits to B then 4 flits to A, continuous valid_i -> zero-bubble switch; B_pkt_cnt_o=1, A_pkt_cnt_o=1; flit order preserved.
- Backpressure: A_ready_i=0 mid-packet -> ready_o drops after 2 buffered flits; A data held stable; B_ready_i toggling has no effect; releasing A_ready_i drains in order.
- Stray BODY then TAIL flit in IDLE -> each dropped with a one-cycle proto_err_o pulse; no output valid; counters unchanged; the following HEAD routes normally.
- rstn=0 asserted while in ROUTE_B with 2 flits buffered -> next cycle buffer empty, state IDLE; a new HEAD with select bit 0 goes to A.
